// File: rtl/pipe_ctrl.sv
// pipe_ctrl: generic valid/payload pipeline with per-stage stall and flush,
// retire backpressure, single-step debug gating and cycle/retire counters.
module pipe_ctrl #(
    parameter int DATA_W = 32,
    parameter int STAGES = 5,
    parameter int CNT_W  = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_in_valid,
    input  logic [DATA_W-1:0]        i_in_data,
    output logic                     o_in_ready,
    input  logic [STAGES-1:0]        i_stall_req,
    input  logic [STAGES-1:0]        i_flush_mask,
    output logic                     o_out_valid,
    output logic [DATA_W-1:0]        o_out_data,
    input  logic                     i_out_ready,
    input  logic                     i_step_mode,
    input  logic                     i_step,
    output logic [STAGES-1:0]        o_stage_valid,
    output logic [STAGES*DATA_W-1:0] o_stage_data,
    output logic [CNT_W-1:0]         o_cycle_cnt,
    output logic [CNT_W-1:0]         o_retire_cnt,
    output logic                     o_halted
);

    logic                           w_en;
    logic                           w_accept;
    logic                           w_retire;
    logic [STAGES:0]                w_rdy;
    logic [STAGES-1:0]              w_go;
    logic [STAGES-1:0]              w_go_up;
    logic [STAGES-1:0][DATA_W-1:0]  w_src;

    logic [STAGES-1:0]              r_valid;
    logic [STAGES-1:0][DATA_W-1:0]  r_data;
    logic [CNT_W-1:0]               r_cycle_cnt;
    logic [CNT_W-1:0]               r_retire_cnt;

    // Pipeline enable: in step mode only a step strobe lets anything move.
    assign w_en     = ~i_step_mode | i_step;
    assign o_halted = i_step_mode & ~i_step;

    // Readiness ripples from the writeback end back towards fetch.
    always_comb begin
        w_rdy         = '0;
        w_go          = '0;
        w_rdy[STAGES] = i_out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_go[i]  = r_valid[i] & ~i_stall_req[i] & w_rdy[i+1] & w_en;
            w_rdy[i] = ~r_valid[i] | w_go[i];
        end
    end

    assign o_in_ready = w_rdy[0] & w_en;
    assign w_accept   = i_in_valid & o_in_ready;

    // out_valid deliberately excludes out_ready so there is no comb loop
    // through the writeback handshake.
    assign o_out_valid = r_valid[STAGES-1] & ~i_stall_req[STAGES-1] & w_en;
    assign o_out_data  = r_data[STAGES-1];
    assign w_retire    = o_out_valid & i_out_ready;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
            if (gi == 0) begin : gen_src_in
                assign w_go_up[gi] = w_accept;
                assign w_src[gi]   = i_in_data;
            end else begin : gen_src_prev
                assign w_go_up[gi] = w_go[gi-1];
                assign w_src[gi]   = r_data[gi-1];
            end

            // Stage register: flush empties the slot (payload kept), an open
            // slot takes whatever moves in from upstream, otherwise hold.
            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    r_valid[gi] <= 1'b0;
                    r_data[gi]  <= '0;
                end else if (i_flush_mask[gi]) begin
                    r_valid[gi] <= 1'b0;
                end else if (w_rdy[gi]) begin
                    r_valid[gi] <= w_go_up[gi];
                    if (w_go_up[gi]) begin
                        r_data[gi] <= w_src[gi];
                    end
                end
            end
        end
    endgenerate

    // Free-running counters of enabled cycles and retire handshakes.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_en) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stage_valid = r_valid;
    assign o_stage_data  = r_data;
    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus a randomized run, all compared
// against a slot-occupancy model of the pipeline.
module tb_pipe_ctrl;

    localparam int S  = 5;
    localparam int DW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic [S-1:0]      stall;
    logic [S-1:0]      flush;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic              step_mode;
    logic              step;
    logic [S-1:0]      stage_valid;
    logic [S*DW-1:0]   stage_data;
    logic [CW-1:0]     cycle_cnt;
    logic [CW-1:0]     retire_cnt;
    logic              halted;

    pipe_ctrl #(.DATA_W(DW), .STAGES(S), .CNT_W(CW)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .i_stall_req  (stall),
        .i_flush_mask (flush),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .i_out_ready  (out_ready),
        .i_step_mode  (step_mode),
        .i_step       (step),
        .o_stage_valid(stage_valid),
        .o_stage_data (stage_data),
        .o_cycle_cnt  (cycle_cnt),
        .o_retire_cnt (retire_cnt),
        .o_halted     (halted)
    );

    int checks = 0;
    int errors = 0;

    // Model: each slot is occupied or not; an occupied slot is "held" when
    // it cannot leave (stalled, disabled, or the slot ahead stays put).
    bit            mv [S];
    logic [DW-1:0] md [S];
    logic [CW-1:0] mcyc;
    logic [CW-1:0] mret;
    bit            m_held [S];
    bit            m_en;
    bit            e_in_ready;
    bit            e_out_valid;
    logic [DW-1:0] got [$];

    task automatic model_comb();
        m_en = !step_mode || step;
        for (int i = S - 1; i >= 0; i--) begin
            bit blocked;
            if (i == S - 1) blocked = !out_ready;
            else            blocked = m_held[i+1];
            m_held[i] = mv[i] && (stall[i] || !m_en || blocked);
        end
        e_in_ready  = m_en && !m_held[0];
        e_out_valid = mv[S-1] && !stall[S-1] && m_en;
    endtask

    task automatic model_edge();
        bit            nv [S];
        logic [DW-1:0] nd [S];
        bit            inc;
        logic [DW-1:0] src;
        model_comb();
        if (!rst_n) begin
            for (int i = 0; i < S; i++) begin
                mv[i] = 1'b0;
                md[i] = '0;
            end
            mcyc = '0;
            mret = '0;
            return;
        end
        for (int i = 0; i < S; i++) begin
            if (i == 0) begin
                inc = in_valid && e_in_ready;
                src = in_data;
            end else begin
                inc = mv[i-1] && !m_held[i-1];
                src = md[i-1];
            end
            nd[i] = md[i];
            if (m_held[i]) begin
                nv[i] = 1'b1;
            end else begin
                nv[i] = inc;
                if (inc) nd[i] = src;
            end
            if (flush[i]) begin
                nv[i] = 1'b0;
                nd[i] = md[i];
            end
        end
        if (mv[S-1] && !m_held[S-1]) mret = mret + 1'b1;
        if (m_en) mcyc = mcyc + 1'b1;
        mv = nv;
        md = nd;
    endtask

    function automatic logic [S-1:0] mvec();
        logic [S-1:0] v;
        for (int i = 0; i < S; i++) v[i] = mv[i];
        return v;
    endfunction

    function automatic logic [S*DW-1:0] mdvec();
        logic [S*DW-1:0] d;
        for (int i = 0; i < S; i++) d[i*DW +: DW] = md[i];
        return d;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_data   = '0;
        stall     = '0;
        flush     = '0;
        out_ready = 1'b1;
        step_mode = 1'b0;
        step      = 1'b0;
    endtask

    task automatic feed(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        if (out_valid && out_ready) got.push_back(out_data);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b0;
            stall    = '0;
            flush    = '0;
            #1;
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (stage_valid !== '0) begin errors++; $display("FAIL reset_valid got %h want 0", stage_valid); end
        checks++; if (stage_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", stage_data); end
        checks++; if (cycle_cnt !== '0) begin errors++; $display("FAIL reset_cycle got %0d want 0", cycle_cnt); end
        checks++; if (retire_cnt !== '0) begin errors++; $display("FAIL reset_retire got %0d want 0", retire_cnt); end
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_flow();
        int            first = -1;
        int            n = 0;
        logic [DW-1:0] nexp = 1;
        idle();
        for (int k = 0; k < 20; k++) begin
            in_valid = (k < 10);
            in_data  = DW'(k + 1);
            #1;
            model_comb();
            checks++; if (in_ready !== e_in_ready) begin errors++; $display("FAIL flow_in_ready cyc %0d got %b want %b", k, in_ready, e_in_ready); end
            checks++; if (out_valid !== e_out_valid) begin errors++; $display("FAIL flow_out_valid cyc %0d got %b want %b", k, out_valid, e_out_valid); end
            if (out_valid) begin
                if (first < 0) first = k;
                checks++; if (out_data !== nexp) begin errors++; $display("FAIL flow_order cyc %0d got %0d want %0d", k, out_data, nexp); end
                nexp++;
                n++;
            end
            tick();
        end
        checks++; if (first !== 5) begin errors++; $display("FAIL flow_latency got %0d want 5", first); end
        checks++; if (n !== 10) begin errors++; $display("FAIL flow_count got %0d want 10", n); end
        checks++; if (retire_cnt !== 4'd10) begin errors++; $display("FAIL flow_retire got %0d want 10", retire_cnt); end
        checks++; if (cycle_cnt !== 4'd4) begin errors++; $display("FAIL flow_cycle got %0d want 4", cycle_cnt); end
        $display("test_flow done first_out=%0d retired=%0d", first, n);
    endtask

    task automatic test_stall();
        logic [CW-1:0] base;
        idle();
        feed(32'hA);
        feed(32'hB);
        feed(32'hC);
        base     = mret;
        in_valid = 1'b1;
        in_data  = 32'hD;
        stall    = 5'b00010;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
        tick();
        checks++; if (stage_valid !== 5'b01011) begin errors++; $display("FAIL stall_valid got %b want 01011", stage_valid); end
        checks++; if (stage_data[3*DW +: DW] !== 32'hA) begin errors++; $display("FAIL stall_s3 got %h want a", stage_data[3*DW +: DW]); end
        checks++; if (stage_data[1*DW +: DW] !== 32'hB) begin errors++; $display("FAIL stall_s1 got %h want b", stage_data[1*DW +: DW]); end
        checks++; if (stage_data[0 +: DW] !== 32'hC) begin errors++; $display("FAIL stall_s0 got %h want c", stage_data[0 +: DW]); end
        checks++; if (stage_data !== mdvec()) begin errors++; $display("FAIL stall_model got %h want %h", stage_data, mdvec()); end
        stall = '0;
        drain(7);
        checks++; if (retire_cnt !== base + 4'd3) begin errors++; $display("FAIL stall_retire got %0d want %0d", retire_cnt, base + 4'd3); end
        checks++; if (stage_valid !== '0) begin errors++; $display("FAIL stall_drained got %b want 0", stage_valid); end
        $display("test_stall done");
    endtask

    task automatic test_flush();
        idle();
        feed(32'h21);
        feed(32'h22);
        feed(32'h23);
        got.delete();
        in_valid = 1'b1;
        in_data  = 32'h24;
        flush    = 5'b00011;
        #1;
        tick();
        checks++; if (stage_valid[1:0] !== 2'b00) begin errors++; $display("FAIL flush_low got %b want 00", stage_valid[1:0]); end
        checks++; if (stage_valid[2] !== 1'b1 || stage_data[2*DW +: DW] !== 32'h22) begin errors++; $display("FAIL flush_s2 got %b/%h want 1/22", stage_valid[2], stage_data[2*DW +: DW]); end
        flush = '0;
        drain(8);
        checks++; if (got.size() !== 2) begin errors++; $display("FAIL flush_count got %0d want 2", got.size()); end
        else begin
            checks++; if (got[0] !== 32'h21 || got[1] !== 32'h22) begin errors++; $display("FAIL flush_seq got %h,%h want 21,22", got[0], got[1]); end
        end
        $display("test_flush done retired=%0d", got.size());
    endtask

    task automatic test_backpressure();
        idle();
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) feed(32'h100 + j);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h1FF;
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b want 1", k, out_valid); end
            tick();
            checks++; if (stage_valid !== 5'h1F) begin errors++; $display("FAIL bp_valid got %b want 11111", stage_valid); end
            checks++; if (stage_data !== {32'h100, 32'h101, 32'h102, 32'h103, 32'h104}) begin errors++; $display("FAIL bp_frozen got %h", stage_data); end
        end
        got.delete();
        out_ready = 1'b1;
        drain(8);
        checks++; if (got.size() !== 5) begin errors++; $display("FAIL bp_count got %0d want 5", got.size()); end
        else begin
            for (int j = 0; j < 5; j++) begin
                checks++; if (got[j] !== 32'h100 + j) begin errors++; $display("FAIL bp_seq idx %0d got %h want %h", j, got[j], 32'h100 + j); end
            end
        end
        $display("test_backpressure done retired=%0d", got.size());
    endtask

    task automatic test_step();
        logic [CW-1:0] base;
        idle();
        feed(32'h55);
        step_mode = 1'b1;
        step      = 1'b0;
        in_valid  = 1'b0;
        base      = mcyc;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            #1;
            checks++; if (halted !== 1'b0) begin errors++; $display("FAIL step_pulse_halted p %0d got %b want 0", p, halted); end
            tick();
            step = 1'b0;
            for (int q = 0; q < 2; q++) begin
                #1;
                checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL step_halted p %0d got %b/%b want 1/0", p, halted, in_ready); end
                tick();
            end
        end
        checks++; if (stage_valid !== 5'b01000) begin errors++; $display("FAIL step_pos got %b want 01000", stage_valid); end
        checks++; if (stage_data[3*DW +: DW] !== 32'h55) begin errors++; $display("FAIL step_data got %h want 55", stage_data[3*DW +: DW]); end
        checks++; if (cycle_cnt !== base + 4'd3) begin errors++; $display("FAIL step_cycle got %0d want %0d", cycle_cnt, base + 4'd3); end
        step_mode = 1'b0;
        drain(4);
        $display("test_step done");
    endtask

    task automatic test_wrap();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 17; j++) feed(32'h300 + j);
        drain(8);
        checks++; if (retire_cnt !== 4'd1) begin errors++; $display("FAIL wrap_retire got %0d want 1", retire_cnt); end
        $display("test_wrap done retire_cnt=%0d", retire_cnt);
    endtask

    task automatic test_reset_mid();
        idle();
        feed(32'h71);
        feed(32'h72);
        feed(32'h73);
        stall    = 5'b00100;
        flush    = 5'b00001;
        in_valid = 1'b1;
        in_data  = 32'h74;
        rst_n    = 1'b0;
        #1;
        tick();
        checks++; if (stage_valid !== '0 || stage_data !== '0) begin errors++; $display("FAIL midreset_state got %b/%h want 0/0", stage_valid, stage_data); end
        checks++; if (cycle_cnt !== '0 || retire_cnt !== '0) begin errors++; $display("FAIL midreset_cnt got %0d/%0d want 0/0", cycle_cnt, retire_cnt); end
        rst_n = 1'b1;
        idle();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        bit sm = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0) sm = ~sm;
            rst_n     = ($urandom_range(0, 63) != 0);
            in_valid  = $urandom_range(0, 1);
            in_data   = $urandom;
            stall     = ($urandom_range(0, 2) == 0) ? S'($urandom) : '0;
            flush     = ($urandom_range(0, 5) == 0) ? S'($urandom) : '0;
            out_ready = ($urandom_range(0, 3) != 0);
            step_mode = sm;
            step      = $urandom_range(0, 1);
            #1;
            model_comb();
            checks++; if (in_ready !== e_in_ready || out_valid !== e_out_valid) begin errors++; $display("FAIL rand_comb cyc %0d got %b/%b want %b/%b", k, in_ready, out_valid, e_in_ready, e_out_valid); end
            checks++; if (halted !== (step_mode && !step)) begin errors++; $display("FAIL rand_halted cyc %0d got %b", k, halted); end
            checks++; if (out_data !== md[S-1]) begin errors++; $display("FAIL rand_out_data cyc %0d got %h want %h", k, out_data, md[S-1]); end
            tick();
            checks++; if (stage_valid !== mvec() || stage_data !== mdvec()) begin errors++; $display("FAIL rand_state cyc %0d got %b want %b", k, stage_valid, mvec()); end
            checks++; if (cycle_cnt !== mcyc || retire_cnt !== mret) begin errors++; $display("FAIL rand_cnt cyc %0d got %0d/%0d want %0d/%0d", k, cycle_cnt, retire_cnt, mcyc, mret); end
        end
        rst_n = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_flow();
        test_stall();
        test_flush();
        test_backpressure();
        test_step();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
